// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: instruction class codes,
// controller state encoding and the load-use compare.
package hazard_ctrl_pkg;

   // Instruction class codes as carried down the pipeline
   localparam logic [2:0] INS_ID_NOP   = 3'd0;
   localparam logic [2:0] INS_ID_RTYPE = 3'd1;
   localparam logic [2:0] INS_ID_LW    = 3'd2;
   localparam logic [2:0] INS_ID_SW    = 3'd3;
   localparam logic [2:0] INS_ID_BEQ   = 3'd4;
   localparam logic [2:0] INS_ID_ADDI  = 3'd5;
   localparam logic [2:0] INS_ID_J     = 3'd6;

   // Controller states
   typedef enum logic [0:0] {
      HzRun    = 1'b0,
      HzLstall = 1'b1
   } hz_state_e;

   // True when the instruction in ID reads the load destination held in EX.
   // rt is a source operand only for R-type, BEQ and SW.
   function automatic logic load_use(input logic [4:0] rs_id,
                                     input logic [4:0] rt_id,
                                     input logic [2:0] ins_id,
                                     input logic [4:0] rt_ex,
                                     input logic [2:0] ins_ex);
      logic rt_src;
      rt_src = (ins_id == INS_ID_RTYPE) || (ins_id == INS_ID_BEQ) || (ins_id == INS_ID_SW);
      return (ins_ex == INS_ID_LW) && (rt_ex != 5'd0) &&
             ((rt_ex == rs_id) || (rt_src && (rt_ex == rt_id)));
   endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes.
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LOAD_FWD = 0,
   parameter int unsigned PERF_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rs_id,
   input  logic [4:0]        rt_id,
   input  logic [2:0]        INS_ID_id,
   input  logic [4:0]        rt_ex,
   input  logic [2:0]        INS_ID_ex,
   input  logic              branch_taken,
   input  logic              jump_id,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_bubble,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_flush,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   hz_state_e  state_q, state_d;
   logic [1:0] scnt_q, scnt_d;
   logic       stall;
   logic       hazard;

   assign hazard = load_use(rs_id, rt_id, INS_ID_id, rt_ex, INS_ID_ex);

   // State and stall-counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HzRun;
         scnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
      end
   end

   // Next state and pipeline control; branch beats stall beats jump
   always_comb begin
      state_d      = state_q;
      scnt_d       = scnt_q;
      stall        = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         state_d      = HzRun;
         scnt_d       = 2'd0;
      end else if (state_q == HzLstall) begin
         stall  = 1'b1;
         scnt_d = scnt_q - 2'd1;
         if (scnt_d == 2'd0) state_d = HzRun;
      end else if (hazard) begin
         stall = 1'b1;
         if (MEM_LOAD_FWD == 0) begin
            state_d = HzLstall;
            scnt_d  = 2'd1;
         end
      end else if (jump_id) begin
         if_id_flush = 1'b1;
      end
      if (stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
      // Hold the pipeline cleared while in reset
      if (!rst_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   localparam logic [PERF_W-1:0] CntOne = {{(PERF_W-1){1'b0}}, 1'b1};

   logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;
   logic              flush_evt;

   assign flush_evt = branch_taken || (jump_id && !stall);

   // Saturating stall-cycle and flush-event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CntOne;
         if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CntOne;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one DUT per MEM_LOAD_FWD setting, shared stimulus.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs_id, rt_id, rt_ex;
   logic [2:0]  ins_id, ins_ex;
   logic        branch_taken, jump_id;

   logic        pc0, ifw0, bub0, iff0, idf0, exf0;
   logic        pc1, ifw1, bub1, iff1, idf1, exf1;
   logic [31:0] sc0, fc0, sc1, fc1;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.MEM_LOAD_FWD(0), .PERF_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .INS_ID_id(ins_id),
      .rt_ex(rt_ex), .INS_ID_ex(ins_ex), .branch_taken(branch_taken), .jump_id(jump_id),
      .pc_write(pc0), .if_id_write(ifw0), .id_ex_bubble(bub0), .if_id_flush(iff0),
      .id_ex_flush(idf0), .ex_mem_flush(exf0), .stall_cnt(sc0), .flush_cnt(fc0)
   );

   hazard_ctrl #(.MEM_LOAD_FWD(1), .PERF_W(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .INS_ID_id(ins_id),
      .rt_ex(rt_ex), .INS_ID_ex(ins_ex), .branch_taken(branch_taken), .jump_id(jump_id),
      .pc_write(pc1), .if_id_write(ifw1), .id_ex_bubble(bub1), .if_id_flush(iff1),
      .id_ex_flush(idf1), .ex_mem_flush(exf1), .stall_cnt(sc1), .flush_cnt(fc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rs_id = 5'd0; rt_id = 5'd0; ins_id = INS_ID_NOP;
      rt_ex = 5'd0; ins_ex = INS_ID_NOP;
      branch_taken = 1'b0; jump_id = 1'b0;
   endtask

   task automatic set_hazard();
      ins_ex = INS_ID_LW; rt_ex = 5'd2;
      ins_id = INS_ID_RTYPE; rs_id = 5'd2; rt_id = 5'd7;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({pc0, ifw0, bub0, iff0, idf0, exf0} !== 6'b000111) begin
         errors++;
         $display("FAIL reset_outputs_fwd0: got %b expected 000111", {pc0, ifw0, bub0, iff0, idf0, exf0});
      end
      checks++;
      if ({pc1, ifw1, bub1, iff1, idf1, exf1} !== 6'b000111) begin
         errors++;
         $display("FAIL reset_outputs_fwd1: got %b expected 000111", {pc1, ifw1, bub1, iff1, idf1, exf1});
      end
      checks++;
      if ({sc0, fc0} !== 64'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", sc0, fc0);
      end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if ({pc0, ifw0, bub0, iff0, idf0, exf0} !== 6'b110000) begin
         errors++;
         $display("FAIL run_after_reset: got %b expected 110000", {pc0, ifw0, bub0, iff0, idf0, exf0});
      end
   endtask

   // Scenarios 1 and 2: two-cycle stall without MEM forward, one cycle with it
   task automatic test_stall_length();
      set_hazard();
      #1;
      checks++;
      if ({pc0, ifw0, bub0} !== 3'b001) begin
         errors++;
         $display("FAIL stall2_cycle1: got %b expected 001", {pc0, ifw0, bub0});
      end
      checks++;
      if ({pc1, ifw1, bub1} !== 3'b001) begin
         errors++;
         $display("FAIL stall1_cycle1: got %b expected 001", {pc1, ifw1, bub1});
      end
      tick();
      // EX now holds the bubble inserted by the stall
      ins_ex = INS_ID_NOP; rt_ex = 5'd0;
      #1;
      checks++;
      if ({pc0, ifw0, bub0} !== 3'b001) begin
         errors++;
         $display("FAIL stall2_cycle2: got %b expected 001", {pc0, ifw0, bub0});
      end
      checks++;
      if ({pc1, ifw1, bub1} !== 3'b110) begin
         errors++;
         $display("FAIL stall1_released: got %b expected 110", {pc1, ifw1, bub1});
      end
      tick();
      checks++;
      if ({pc0, ifw0, bub0} !== 3'b110) begin
         errors++;
         $display("FAIL stall2_released: got %b expected 110", {pc0, ifw0, bub0});
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (sc0 !== 32'd2 || sc1 !== 32'd1 || fc0 !== 32'd0) begin
         errors++;
         $display("FAIL perf_stall_cnt: got %0d/%0d/%0d expected 2/1/0", sc0, sc1, fc0);
      end
`else
      checks++;
      if (sc0 !== 32'd0 || fc1 !== 32'd0) begin
         errors++;
         $display("FAIL perf_disabled: got %0d/%0d expected 0/0", sc0, fc1);
      end
`endif
   endtask

   // Scenario 3: register 0 never hazards; rt counts only for consumers of rt
   task automatic test_load_cases();
      set_idle();
      ins_ex = INS_ID_LW; rt_ex = 5'd0; ins_id = INS_ID_RTYPE; rs_id = 5'd0;
      #1;
      checks++;
      if (pc0 !== 1'b1 || bub0 !== 1'b0) begin
         errors++;
         $display("FAIL lw_r0_no_stall: got pc=%b bub=%b expected pc=1 bub=0", pc0, bub0);
      end
      ins_ex = INS_ID_LW; rt_ex = 5'd3; ins_id = INS_ID_ADDI; rs_id = 5'd1; rt_id = 5'd3;
      #1;
      checks++;
      if (pc0 !== 1'b1) begin
         errors++;
         $display("FAIL addi_rt_no_stall: got pc=%b expected 1", pc0);
      end
      ins_id = INS_ID_SW;
      #1;
      checks++;
      if ({pc0, bub0, pc1, bub1} !== 4'b0101) begin
         errors++;
         $display("FAIL sw_rt_stall: got %b expected 0101", {pc0, bub0, pc1, bub1});
      end
      tick();
      set_idle();
      tick();
      #1;
   endtask

   // Scenario 4: taken branch in the LSTALL cycle overrides the stall
   task automatic test_branch_in_stall();
      set_hazard();
      tick();
      set_idle();
      branch_taken = 1'b1;
      #1;
      checks++;
      if ({pc0, ifw0, bub0, iff0, idf0, exf0} !== 6'b110111) begin
         errors++;
         $display("FAIL branch_in_lstall: got %b expected 110111", {pc0, ifw0, bub0, iff0, idf0, exf0});
      end
      tick();
      branch_taken = 1'b0;
      #1;
      checks++;
      if ({pc0, ifw0, bub0, iff0, idf0, exf0} !== 6'b110000) begin
         errors++;
         $display("FAIL run_after_branch: got %b expected 110000", {pc0, ifw0, bub0, iff0, idf0, exf0});
      end
      // Branch also wins over a fresh load-use hazard in RUN
      set_hazard();
      branch_taken = 1'b1;
      #1;
      checks++;
      if ({pc0, bub0, exf0} !== 3'b101) begin
         errors++;
         $display("FAIL branch_over_hazard: got %b expected 101", {pc0, bub0, exf0});
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (pc0 !== 1'b1) begin
         errors++;
         $display("FAIL no_stall_after_branch: got pc=%b expected 1", pc0);
      end
   endtask

   // Scenario 5: jump flushes IF/ID only; jump under a stall is ignored
   task automatic test_jump();
      logic [31:0] fc_before;
      set_idle();
      fc_before = fc0;
      jump_id = 1'b1;
      #1;
      checks++;
      if ({pc0, iff0, idf0, exf0} !== 4'b1100) begin
         errors++;
         $display("FAIL jump_alone: got %b expected 1100", {pc0, iff0, idf0, exf0});
      end
      tick();
`ifdef HAZARD_PERF_EN
      checks++;
      if (fc0 !== fc_before + 32'd1) begin
         errors++;
         $display("FAIL perf_flush_cnt: got %0d expected %0d", fc0, fc_before + 32'd1);
      end
`endif
      set_hazard();
      jump_id = 1'b1;
      #1;
      checks++;
      if ({pc0, bub0, iff0, idf0, exf0} !== 5'b01000) begin
         errors++;
         $display("FAIL jump_with_hazard: got %b expected 01000", {pc0, bub0, iff0, idf0, exf0});
      end
      tick();
      ins_ex = INS_ID_NOP; rt_ex = 5'd0;
      #1;
      checks++;
      if ({pc0, bub0, iff0} !== 3'b010) begin
         errors++;
         $display("FAIL jump_in_lstall: got %b expected 010", {pc0, bub0, iff0});
      end
      tick();
      set_idle();
      #1;
   endtask

   // Scenario 6: asynchronous reset during LSTALL returns to RUN without a clock edge
   task automatic test_reset_mid_stall();
      set_hazard();
      tick();
      set_idle();
      #1;
      checks++;
      if (pc0 !== 1'b0) begin
         errors++;
         $display("FAIL in_lstall_before_reset: got pc=%b expected 0", pc0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pc0, ifw0, bub0, iff0, idf0, exf0} !== 6'b000111) begin
         errors++;
         $display("FAIL reset_mid_stall: got %b expected 000111", {pc0, ifw0, bub0, iff0, idf0, exf0});
      end
      checks++;
      if ({sc0, fc0, sc1, fc1} !== 128'd0) begin
         errors++;
         $display("FAIL counters_cleared: got %0d/%0d expected 0/0", sc0, fc0);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({pc0, ifw0, bub0, iff0, idf0, exf0} !== 6'b110000) begin
         errors++;
         $display("FAIL run_after_mid_reset: got %b expected 110000", {pc0, ifw0, bub0, iff0, idf0, exf0});
      end
   endtask

   initial begin
      test_reset();
      test_stall_length();
      test_load_cases();
      test_branch_in_stall();
      test_jump();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
